// File: rtl/filter_pkg.sv
// Shared types and helpers for the streaming binary window filter.
package filter_pkg;

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  // Window counts reach at most 9*9 = 81, so 8 bits suffice for wc/bc.
  localparam int CNT8_W = 8;
  // 81 * 255 fits in 16 bits, so the ratio products never truncate.
  localparam int PROD_W = 16;

  function automatic int half_of(input int filter_size);
    return filter_size >> 1;
  endfunction

  function automatic int prod_width(input int filter_size, input int den);
    return $clog2(filter_size * filter_size * den + 1);
  endfunction

  function automatic logic coverage_pass(input logic [CNT8_W-1:0] wc,
                                         input logic [CNT8_W-1:0] bc,
                                         input logic [CNT8_W-1:0] num,
                                         input logic [CNT8_W-1:0] den);
    logic [PROD_W-1:0] lhs;
    logic [PROD_W-1:0] rhs;
    lhs = PROD_W'(wc) * PROD_W'(den);
    rhs = PROD_W'(bc) * PROD_W'(num);
    return lhs > rhs;
  endfunction

endpackage

// File: rtl/line_buffer_bits.sv
// One line of 1-bit pixel history; dout is the pixel shifted in WIDTH steps ago.
module line_buffer_bits #(
  parameter int WIDTH = 256
) (
  input  logic clk,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [WIDTH-1:0] taps;

  // Contents are never cleared; stale bits are masked by the window bounds.
  always_ff @(posedge clk) begin
    if (en) taps <= {taps[WIDTH-2:0], din};
  end

  assign dout = taps[WIDTH-1];

endmodule

// File: rtl/binary_window_filter_stream.sv
// Streaming FILTER_SIZE x FILTER_SIZE coverage-ratio filter over a binary mask,
// using line buffers and per-position bounds masking instead of frame RAMs.
module binary_window_filter_stream
  import filter_pkg::*;
#(
  parameter int WIDTH       = 256,
  parameter int DEPTH       = 256,
  parameter int FILTER_SIZE = 5,
  parameter int RATIO_NUM   = 7,
  parameter int RATIO_DEN   = 8,
  parameter int CNT_W       = $clog2(WIDTH * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic [CNT_W-1:0] white_count,
  output logic             frame_done,
  output logic             busy
);

  localparam int HALF      = half_of(FILTER_SIZE);
  localparam int PIXELS    = WIDTH * DEPTH;
  localparam int FILL_LAST = HALF * WIDTH + HALF;
  localparam int XW        = $clog2(WIDTH);
  localparam int YW        = $clog2(DEPTH);
  localparam int IW        = $clog2(PIXELS);

  state_t                 state;
  logic [IW-1:0]          in_idx;
  logic [XW-1:0]          gen_x;
  logic [YW-1:0]          gen_y;
  logic                   gen_done;
  logic [CNT_W-1:0]       run_count;
  logic [FILTER_SIZE-1:0] win      [FILTER_SIZE];
  logic [FILTER_SIZE-1:0] next_win [FILTER_SIZE];
  logic [FILTER_SIZE-1:0] column;
  logic                   lb_tap   [FILTER_SIZE-1];
  logic                   in_beat, step, emit, feed_pixel, filt_pixel;
  logic [CNT8_W-1:0]      wc, bc;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE, FILL: in_ready = 1'b1;
      RUN:        in_ready = out_ready || !out_valid;
      default:    in_ready = 1'b0;
    endcase
  end

  // One step shifts the whole window; in FLUSH, zeros stand in for missing input.
  assign in_beat    = in_valid && in_ready;
  assign step       = (in_beat && (state != IDLE || in_sof)) ||
                      (state == FLUSH && !gen_done && (out_ready || !out_valid));
  assign emit       = step && (state == RUN || state == FLUSH ||
                               (state == FILL && in_idx == IW'(FILL_LAST)));
  assign feed_pixel = (state == FLUSH) ? 1'b0 : in_pixel;

  for (genvar g = 0; g < FILTER_SIZE - 1; g++) begin : g_lines
    if (g == 0) begin : g_first
      line_buffer_bits #(.WIDTH(WIDTH)) u_line (
        .clk (clk), .en (step), .din (feed_pixel), .dout (lb_tap[g]));
    end else begin : g_chain
      line_buffer_bits #(.WIDTH(WIDTH)) u_line (
        .clk (clk), .en (step), .din (lb_tap[g-1]), .dout (lb_tap[g]));
    end
  end

  // Bit dx of row dy holds the pixel at (gen_x+HALF-dx, gen_y+HALF-dy).
  always_comb begin
    int xi;
    int yi;
    column    = '0;
    column[0] = feed_pixel;
    for (int dy = 1; dy < FILTER_SIZE; dy++) column[dy] = lb_tap[dy-1];
    wc = '0;
    bc = '0;
    for (int dy = 0; dy < FILTER_SIZE; dy++) begin
      next_win[dy] = {win[dy][FILTER_SIZE-2:0], column[dy]};
      for (int dx = 0; dx < FILTER_SIZE; dx++) begin
        xi = int'(gen_x) + HALF - dx;
        yi = int'(gen_y) + HALF - dy;
        if (xi >= 0 && xi < WIDTH && yi >= 0 && yi < DEPTH) begin
          bc = bc + 8'd1;
          if (next_win[dy][dx]) wc = wc + 8'd1;
        end
      end
    end
    filt_pixel = coverage_pass(wc, bc, CNT8_W'(RATIO_NUM), CNT8_W'(RATIO_DEN));
  end

  always_ff @(posedge clk) begin
    if (step) win <= next_win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_idx      <= '0;
      gen_x       <= '0;
      gen_y       <= '0;
      gen_done    <= 1'b0;
      run_count   <= '0;
      white_count <= '0;
      out_valid   <= 1'b0;
      out_pixel   <= 1'b0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      out_eof     <= 1'b0;
    end else begin
      if (emit) begin
        out_valid <= 1'b1;
        out_pixel <= filt_pixel;
        out_sof   <= (gen_x == '0) && (gen_y == '0);
        out_eol   <= (gen_x == XW'(WIDTH - 1));
        out_eof   <= (gen_x == XW'(WIDTH - 1)) && (gen_y == YW'(DEPTH - 1));
        if (gen_x == XW'(WIDTH - 1)) begin
          gen_x <= '0;
          if (gen_y == YW'(DEPTH - 1)) gen_done <= 1'b1;
          else                         gen_y    <= gen_y + 1'b1;
        end else begin
          gen_x <= gen_x + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready && out_pixel) run_count <= run_count + 1'b1;

      case (state)
        IDLE: if (in_beat && in_sof) begin
          state     <= FILL;
          in_idx    <= IW'(1);
          gen_x     <= '0;
          gen_y     <= '0;
          gen_done  <= 1'b0;
          run_count <= '0;
        end
        FILL: if (in_beat) begin
          in_idx <= in_idx + 1'b1;
          if (in_idx == IW'(FILL_LAST)) state <= RUN;
        end
        RUN: if (in_beat) begin
          in_idx <= in_idx + 1'b1;
          if (in_idx == IW'(PIXELS - 1)) state <= FLUSH;
        end
        FLUSH: if (gen_done && out_valid && out_ready && out_eof) state <= DONE;
        DONE: begin
          white_count <= run_count;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign frame_done = (state == DONE);
  assign busy       = (state == FILL) || (state == RUN) || (state == FLUSH);

endmodule

// File: tb/tb_binary_window_filter_stream.sv
// Directed bench for binary_window_filter_stream on an 8x6 frame with a 3x3 window, 7/8 ratio.
module tb_binary_window_filter_stream;

  localparam int W = 8;
  localparam int D = 6;
  localparam int N = W * D;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_pixel, in_sof;
  logic          out_valid, out_ready, out_pixel, out_sof, out_eol, out_eof;
  logic [CW-1:0] white_count;
  logic          frame_done, busy;

  int tests_run = 0;
  int failures  = 0;

  localparam logic [N-1:0] IMG_ONES    = 48'hFFFFFFFFFFFF;
  localparam logic [N-1:0] IMG_BLOCK   = 48'h001C1C1C0000;
  localparam logic [N-1:0] EXP_BLOCK   = 48'h000008000000;
  localparam logic [N-1:0] IMG_SINGLE  = 48'h000008000000;
  localparam logic [N-1:0] IMG_CORNERS = 48'hC0C000000303;
  localparam logic [N-1:0] EXP_CORNERS = 48'h800000000001;

  binary_window_filter_stream #(
    .WIDTH(W), .DEPTH(D), .FILTER_SIZE(3), .RATIO_NUM(7), .RATIO_DEN(8), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .white_count(white_count), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drives one frame and collects outputs; stops one cycle after frame_done, at abort_at accepted inputs, or at the cycle budget.
  task automatic applyStimulus(input logic [N-1:0] img, input int gap_pct, input int stall_pct,
                               input int abort_at, output logic [N-1:0] got, output int n_out,
                               output int first_acc, output int flag_err, output int stab_err,
                               output int done_pulses, output int wc_nonzero, output int busy_seen);
    int acc = 0;
    logic pend = 1'b0;
    logic hold = 1'b0;
    logic [3:0] hv = '0;
    got = '0; n_out = 0; first_acc = -1; flag_err = 0; stab_err = 0;
    done_pulses = 0; wc_nonzero = 0; busy_seen = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      if (!pend) begin
        if (acc < N && $urandom_range(99) >= gap_pct) begin
          in_valid = 1'b1; in_pixel = img[acc]; in_sof = (acc == 0);
        end else begin
          in_valid = 1'b0; in_pixel = 1'b0; in_sof = 1'b0;
        end
      end
      #1;
      if (out_valid && first_acc < 0) first_acc = acc;
      if (hold && {out_pixel, out_sof, out_eol, out_eof} !== hv) stab_err++;
      hold = out_valid && !out_ready;
      hv   = {out_pixel, out_sof, out_eol, out_eof};
      if (out_valid && out_ready) begin
        if (n_out < N) got[n_out] = out_pixel;
        if (out_sof !== (n_out == 0) || out_eol !== ((n_out % W) == W - 1) ||
            out_eof !== (n_out == N - 1)) flag_err++;
        n_out++;
      end
      if (done_pulses == 0 && white_count !== '0) wc_nonzero++;
      if (busy) busy_seen++;
      if (frame_done) done_pulses++;
      if (in_valid && in_ready) begin acc++; pend = 1'b0; end
      else pend = in_valid;
      if (abort_at > 0 && acc >= abort_at) break;
      if (done_pulses > 0 && !frame_done) break;
    end
    in_valid = 1'b0; in_pixel = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] img, input logic [N-1:0] exp_img,
                             input int exp_white, input int gap_pct, input int stall_pct);
    logic [N-1:0] got;
    int n_out, first_acc, flag_err, stab_err, done_pulses, wc_nonzero, busy_seen;
    applyStimulus(img, gap_pct, stall_pct, 0, got, n_out, first_acc, flag_err, stab_err,
                  done_pulses, wc_nonzero, busy_seen);
    tests_run++;
    if (got !== exp_img) begin failures++; $display("[TB] FAIL %s pixels got=%h exp=%h", name, got, exp_img); end
    tests_run++;
    if (n_out !== N) begin failures++; $display("[TB] FAIL %s beats got=%0d exp=%0d", name, n_out, N); end
    tests_run++;
    if (flag_err !== 0) begin failures++; $display("[TB] FAIL %s sof/eol/eof errors got=%0d exp=0", name, flag_err); end
    tests_run++;
    if (done_pulses !== 1) begin failures++; $display("[TB] FAIL %s frame_done pulses got=%0d exp=1", name, done_pulses); end
    tests_run++;
    if (white_count !== CW'(exp_white)) begin failures++; $display("[TB] FAIL %s white_count got=%0d exp=%0d", name, white_count, exp_white); end
    tests_run++;
    if (busy !== 1'b0 || busy_seen == 0) begin failures++; $display("[TB] FAIL %s busy end=%b seen=%0d exp end=0 seen>0", name, busy, busy_seen); end
    if (stall_pct == 0 && gap_pct == 0) begin
      tests_run++;
      if (first_acc !== 10) begin failures++; $display("[TB] FAIL %s latency inputs_before_first_out got=%0d exp=10", name, first_acc); end
    end else begin
      tests_run++;
      if (stab_err !== 0) begin failures++; $display("[TB] FAIL %s stall stability errors got=%0d exp=0", name, stab_err); end
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({in_ready, out_valid, out_pixel, out_sof, out_eol, out_eof, frame_done, busy} !== 8'b1000_0000) begin
      failures++; $display("[TB] FAIL reset outputs got=%b exp=10000000",
        {in_ready, out_valid, out_pixel, out_sof, out_eol, out_eof, frame_done, busy});
    end
    tests_run++;
    if (white_count !== '0) begin failures++; $display("[TB] FAIL reset white_count got=%0d exp=0", white_count); end
  endtask

  task automatic test_all_ones();   checkOutput("all_ones", IMG_ONES, IMG_ONES, 48, 0, 0);           endtask
  task automatic test_all_zeros();  checkOutput("all_zeros", '0, '0, 0, 0, 0);                        endtask
  task automatic test_block();      checkOutput("block", IMG_BLOCK, EXP_BLOCK, 1, 0, 0);              endtask
  task automatic test_single();     checkOutput("single", IMG_SINGLE, '0, 0, 0, 0);                   endtask
  task automatic test_corners();    checkOutput("corners", IMG_CORNERS, EXP_CORNERS, 2, 0, 0);        endtask
  task automatic test_back_to_back(); checkOutput("stalled_block", IMG_BLOCK, EXP_BLOCK, 1, 30, 50);  endtask

  task automatic test_idle_drop();
    int seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_pixel = 1'b1; in_sof = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid || busy || !in_ready) seen++;
    end
    @(negedge clk); in_valid = 1'b0; in_pixel = 1'b0;
    #1;
    if (out_valid || busy) seen++;
    tests_run++;
    if (seen !== 0) begin failures++; $display("[TB] FAIL idle_drop activity cycles got=%0d exp=0", seen); end
    checkOutput("after_drop", IMG_CORNERS, EXP_CORNERS, 2, 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    logic [N-1:0] got;
    int n_out, first_acc, flag_err, stab_err, done_pulses, wc_nonzero, busy_seen;
    applyStimulus(IMG_BLOCK, 0, 0, 20, got, n_out, first_acc, flag_err, stab_err,
                  done_pulses, wc_nonzero, busy_seen);
    #2 rst_n = 1'b0;
    #2;
    tests_run++;
    if ({in_ready, out_valid, busy, frame_done} !== 4'b1000 || white_count !== '0) begin
      failures++; $display("[TB] FAIL mid_reset state got=%b wc=%0d exp=1000 wc=0",
        {in_ready, out_valid, busy, frame_done}, white_count);
    end
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(IMG_BLOCK, 0, 0, 0, got, n_out, first_acc, flag_err, stab_err,
                  done_pulses, wc_nonzero, busy_seen);
    tests_run++;
    if (got !== EXP_BLOCK || n_out !== N) begin failures++; $display("[TB] FAIL post_reset pixels got=%h n=%0d exp=%h n=%0d", got, n_out, EXP_BLOCK, N); end
    tests_run++;
    if (wc_nonzero !== 0) begin failures++; $display("[TB] FAIL post_reset early white_count cycles got=%0d exp=0", wc_nonzero); end
    tests_run++;
    if (white_count !== CW'(1)) begin failures++; $display("[TB] FAIL post_reset white_count got=%0d exp=1", white_count); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pixel = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_all_ones();
    test_all_zeros();
    test_block();
    test_single();
    test_corners();
    test_back_to_back();
    test_idle_drop();
    test_block();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/binary_window_filter_stream.md
Name: binary_window_filter_stream

Overview:
- Streaming successor to the frame-buffered low-pass filter.
- Takes a binary skin mask in raster order, one pixel per accepted beat, and applies a FILTER_SIZE x FILTER_SIZE coverage-ratio filter using FILTER_SIZE-1 line buffers instead of full-frame RAMs.
- Output pixel is white when the white fraction of in-bounds window pixels exceeds RATIO_NUM/RATIO_DEN.
- Sits between skin classification and centroid; ready/valid on both sides; also reports a per-frame white count.

Parameters:
- WIDTH, 256, pixels per line (>= FILTER_SIZE)
- DEPTH, 256, lines per frame (>= FILTER_SIZE)
- FILTER_SIZE, 5, window edge; odd, 3..9
- RATIO_NUM, 7, coverage ratio numerator
- RATIO_DEN, 8, coverage ratio denominator (> RATIO_NUM)
- CNT_W, $clog2(WIDTH*DEPTH+1), width of white_count

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat
- in_pixel  in  1  mask pixel, 1 = white
- in_sof  in  1  start of frame; qualifies the first pixel
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_pixel  out  1  filtered pixel
- out_sof  out  1  first output pixel of frame
- out_eol  out  1  last pixel of a line
- out_eof  out  1  last pixel of frame
- white_count  out  CNT_W  white output pixels of the last completed frame
- frame_done  out  1  one-cycle pulse after the out_eof beat is accepted
- busy  out  1  high from sof accept until frame_done

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except in_ready=1; line buffers need no clearing; white_count=0.
- Definitions: HALF=FILTER_SIZE>>1. Beat = valid&&ready.
- States:
  - IDLE:
    - in_ready=1.
    - A beat without in_sof is dropped.
    - A beat with in_sof stores pixel (0,0) -> FILL.
  - FILL:
    - Accept input; no output.
    - After input index HALF*WIDTH+HALF is accepted -> RUN.
  - RUN:
    - Each input beat produces one output beat.
    - in_ready = out_ready || !out_valid, giving single-stage backpressure; the whole window pipeline stalls together.
    - After the last input pixel (WIDTH-1, DEPTH-1) is accepted -> FLUSH.
  - FLUSH:
    - in_ready=0.
    - Emit the remaining HALF*WIDTH+HALF outputs, feeding 0 into the window as "out of bounds".
    - After the out_eof beat -> DONE.
  - DONE: one cycle; frame_done=1, white_count updated -> IDLE.
- Output order and latency:
  - Output is raster-ordered, exactly WIDTH*DEPTH beats.
  - Output (x,y) becomes valid the cycle after input (x+HALF, y+HALF) is accepted, or during flush when that input does not exist.
  - Pipeline fill latency: HALF*WIDTH+HALF accepted inputs.
- in_sof outside IDLE is ignored (treated as data).
- Window arithmetic:
  - wc = count of white in-bounds pixels.
  - bc = count of in-bounds positions, 1..FILTER_SIZE^2.
  - Out-of-bounds positions (x or y outside frame) contribute to neither count; edges are never replicated.
  - out_pixel = (wc*RATIO_DEN > bc*RATIO_NUM).
  - Exact integer compare; products sized $clog2(FILTER_SIZE^2*RATIO_DEN+1) bits; no truncation.
- Line-wrap: window columns crossing a line boundary are masked by the column bound, never mixed with the previous line.
- Output holding: out_pixel, out_sof, out_eol and out_eof are held stable while out_valid && !out_ready.
- white_count: a running count of white output beats; latched at DONE and held until the next DONE. The running counter clears on sof accept.
- Reset mid-frame: immediate return to IDLE; partial frame discarded; white_count cleared to 0.

Decomposition:
- Package filter_pkg:
  - state enum (IDLE, FILL, RUN, FLUSH, DONE)
  - HALF and product-width localparams
  - function coverage_pass(wc, bc)
- Sub-module line_buffer_bits:
  - one WIDTH-deep, 1-bit shift line with enable.
  - instantiated FILTER_SIZE-1 times by generate.
- The window register array and bounds counters stay in the top.

Test Plan:
- WIDTH=8, DEPTH=6, FILTER_SIZE=3, 7/8: all-ones frame -> 48 ones (corner: wc=bc=4, 32>28); white_count=48; one frame_done pulse.
- Same config, all-zeros frame -> 48 zeros; white_count=0; out_sof on beat 0, out_eol every 8th, out_eof on beat 47.
- 3x3 white block centred at (3,3) -> only (3,3) white (edge neighbours wc=6: 48>63 false); white_count=1. Single isolated white pixel -> white_count=0.
- Random out_ready (50%) and random in_valid gaps on the block frame -> output sequence identical to the unstalled run; no beat lost or duplicated; outputs stable while stalled.
- Beats without in_sof in IDLE -> dropped, no output. Assert rst_n low at input beat 20, then send a full frame -> outputs match a clean run; white_count reads 0 until the first DONE.
- FILTER_SIZE=5, 256x256 random mask -> matches a software model with the same bounds rule; first out_valid the cycle after input 514 (2*256+2) is accepted.
